// File: rtl/seq_detect_sequencer_if.sv
// Word-side handshake, detector link and result bus of seq_detect_sequencer.
// slave = sequencer side, master = word source / detector side.
interface seq_detect_sequencer_if #(
   parameter int WORD_W = 8,
   parameter int CNT_W  = 4
);
   logic [WORD_W-1:0] word_in;
   logic              word_valid;
   logic              word_ready;
   logic              ser_out;
   logic              det_reset;
   logic              det_hit;
   logic              busy;
   logic              done;
   logic [WORD_W-1:0] hit_mask;
   logic [CNT_W-1:0]  hit_count;

   modport slave (
      input  word_in, word_valid, det_hit,
      output word_ready, ser_out, det_reset,
      output busy, done, hit_mask, hit_count
   );

   modport master (
      output word_in, word_valid, det_hit,
      input  word_ready, ser_out, det_reset,
      input  busy, done, hit_mask, hit_count
   );
endinterface

// File: rtl/seq_detect_sequencer.sv
// Shifts parallel words MSB-first into a serial detector and collects hits.
// SEQ_CHAIN_EN: detector is cleared only for the first word after reset.
module seq_detect_sequencer #(
   parameter int WORD_W = 8,
   parameter int CNT_W  = 4
) (
   input logic                   clock,
   input logic                   reset,
   seq_detect_sequencer_if.slave sq_if
);
   localparam int KW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   typedef enum logic [2:0] {
      IDLE, CLR, SHIFT, DRAIN, DONE
   } state_e;

   state_e            state_q;
   logic [WORD_W-1:0] sreg_q;
   logic [WORD_W-1:0] ptr_q;
   logic [WORD_W-1:0] mask_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic [KW-1:0]     k_q;
   logic              ser_q;
   logic              busy_q;
   logic              done_q;
   logic              ready_q;
   logic              accept;
   logic              sample;
`ifdef SEQ_CHAIN_EN
   logic              first_q;
`endif

   assign accept = ready_q & sq_if.word_valid;
   // F lags the bit presented by one cycle
   assign sample = sq_if.det_hit &
                   (((state_q == SHIFT) & (k_q != '0)) |
                    (state_q == DRAIN));
   assign cnt_d  = (sample & (cnt_q != '1)) ?
                   cnt_q + CNT_W'(1) : cnt_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         ptr_q   <= '0;
         mask_q  <= '0;
         cnt_q   <= '0;
         k_q     <= '0;
         ser_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
`ifdef SEQ_CHAIN_EN
         first_q <= 1'b1;
`endif
      end else begin
         if (sample) mask_q <= mask_q | ptr_q;
         cnt_q <= cnt_d;
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  mask_q  <= '0;
                  cnt_q   <= '0;
                  k_q     <= '0;
                  ptr_q   <= {1'b1, {(WORD_W-1){1'b0}}};
`ifdef SEQ_CHAIN_EN
                  first_q <= 1'b0;
                  if (first_q) begin
                     sreg_q  <= sq_if.word_in;
                     state_q <= CLR;
                  end else begin
                     ser_q   <= sq_if.word_in[WORD_W-1];
                     sreg_q  <= sq_if.word_in << 1;
                     state_q <= SHIFT;
                  end
`else
                  sreg_q  <= sq_if.word_in;
                  state_q <= CLR;
`endif
               end
            end
            CLR: begin
               ser_q   <= sreg_q[WORD_W-1];
               sreg_q  <= sreg_q << 1;
               state_q <= SHIFT;
            end
            SHIFT: begin
               if (k_q != '0) ptr_q <= ptr_q >> 1;
               if (k_q == KW'(WORD_W-1)) begin
                  ser_q   <= 1'b0;
                  state_q <= DRAIN;
               end else begin
                  ser_q  <= sreg_q[WORD_W-1];
                  sreg_q <= sreg_q << 1;
                  k_q    <= k_q + KW'(1);
               end
            end
            DRAIN: begin
               done_q  <= 1'b1;
               state_q <= DONE;
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sq_if.word_ready = ready_q;
   assign sq_if.ser_out    = ser_q;
   assign sq_if.det_reset  = reset | (state_q == CLR);
   assign sq_if.busy       = busy_q;
   assign sq_if.done       = done_q;
   assign sq_if.hit_mask   = mask_q;
   assign sq_if.hit_count  = cnt_q;
endmodule

// File: tb/tb_seq_detect_sequencer.sv
// Bench for seq_detect_sequencer: "101" detector model plus
// result scoreboards for an 8-bit and a 16-bit instance.
module tb_seq_detect_sequencer;
   localparam bit CH =
`ifdef SEQ_CHAIN_EN
      1'b1;
`else
      1'b0;
`endif

   logic clk;
   logic rst8;
   logic rst16;
   int   n_chk;
   int   n_fail;
   int   cyc;
   int   acc8;
   int   acc16;
   int   pulses8;
   int   sh8;
   int   sh16;
   bit   f8;
   bit   f16;
   logic [1:0]  d8;
   logic [1:0]  d16;
   logic [19:0] e8;
   logic [25:0] e16;
   logic [19:0] q8[$];
   logic [25:0] q16[$];

   seq_detect_sequencer_if #(.WORD_W(8), .CNT_W(4)) bus8 ();
   seq_detect_sequencer_if #(.WORD_W(16), .CNT_W(2)) bus16 ();

   seq_detect_sequencer #(.WORD_W(8), .CNT_W(4)) u_dut8 (
      .clock (clk),
      .reset (rst8),
      .sq_if (bus8.slave)
   );

   seq_detect_sequencer #(.WORD_W(16), .CNT_W(2)) u_dut16 (
      .clock (clk),
      .reset (rst16),
      .sq_if (bus16.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] nx(input logic [1:0] s, input logic b);
      case (s)
         2'd0:    nx = b ? 2'd1 : 2'd0;
         2'd1:    nx = b ? 2'd1 : 2'd2;
         2'd2:    nx = b ? 2'd3 : 2'd0;
         default: nx = b ? 2'd1 : 2'd2;
      endcase
   endfunction

   // Moore "101" detector; advances only on cycles carrying word bits
   always @(posedge clk) begin
      if (bus8.det_reset) d8 <= 2'd0;
      else if (sh8 != 0) d8 <= nx(d8, bus8.ser_out);
      if (bus16.det_reset) d16 <= 2'd0;
      else if (sh16 != 0) d16 <= nx(d16, bus16.ser_out);
   end
   assign bus8.det_hit  = (d8 == 2'd3);
   assign bus16.det_hit = (d16 == 2'd3);

   always @(posedge clk) begin
      if (rst8) begin
         sh8 <= 0;
         f8  <= 1'b1;
      end else begin
         if (sh8 != 0) sh8 <= sh8 - 1;
         if (bus8.det_reset) sh8 <= 8;
         if (bus8.word_valid && bus8.word_ready) begin
            f8 <= 1'b0;
            if (CH && !f8) sh8 <= 8;
         end
      end
      if (rst16) begin
         sh16 <= 0;
         f16  <= 1'b1;
      end else begin
         if (sh16 != 0) sh16 <= sh16 - 1;
         if (bus16.det_reset) sh16 <= 16;
         if (bus16.word_valid && bus16.word_ready) begin
            f16 <= 1'b0;
            if (CH && !f16) sh16 <= 16;
         end
      end
   end

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!rst8 && bus8.word_valid && bus8.word_ready) acc8 = cyc;
      if (!rst16 && bus16.word_valid && bus16.word_ready) acc16 = cyc;
      if (!rst8 && bus8.det_reset) pulses8 = pulses8 + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (bus8.done === 1'b1) begin
         if (q8.size() == 0) chk("done8_unexpected", bus8.done, 0);
         else begin
            e8 = q8.pop_front();
            chk("mask8", bus8.hit_mask, e8[7:0]);
            chk("cnt8", bus8.hit_count, e8[11:8]);
            chk("lat8", cyc - acc8 + 1, e8[19:12]);
         end
      end
      if (bus16.done === 1'b1) begin
         if (q16.size() == 0) chk("done16_unexpected", bus16.done, 0);
         else begin
            e16 = q16.pop_front();
            chk("mask16", bus16.hit_mask, e16[15:0]);
            chk("cnt16", bus16.hit_count, e16[17:16]);
            chk("lat16", cyc - acc16 + 1, e16[25:18]);
         end
      end
   end

   task automatic send8(input logic [7:0] w, input bit push,
                        input logic [7:0] m, input logic [3:0] c,
                        input int lat);
      int n;
      if (push) q8.push_back({lat[7:0], c, m});
      bus8.word_in    = w;
      bus8.word_valid = 1'b1;
      n = 0;
      while (bus8.word_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("ready8_timeout", n < 100, 1);
      @(negedge clk);
      bus8.word_valid = 1'b0;
   endtask

   task automatic wait_idle8();
      int n;
      n = 0;
      while (q8.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("idle8_timeout", q8.size(), 0);
   endtask

   initial begin
      logic [7:0] w;
      int n;
      int base;
      n_chk = 0;
      n_fail = 0;
      cyc = 0;
      acc8 = 0;
      acc16 = 0;
      pulses8 = 0;
      rst8 = 1'b1;
      rst16 = 1'b1;
      bus16.word_in = '0;
      bus16.word_valid = 1'b0;
      // valid held through reset must not be taken
      w = 8'hA5;
      bus8.word_in = w;
      bus8.word_valid = 1'b1;
      q8.push_back({8'd11, 4'd2, 8'b00100001});
      repeat (3) @(negedge clk);
      chk("rst_ready", bus8.word_ready, 1);
      chk("rst_busy", bus8.busy, 0);
      chk("rst_done", bus8.done, 0);
      chk("rst_mask", bus8.hit_mask, 0);
      chk("rst_cnt", bus8.hit_count, 0);
      chk("rst_ser", bus8.ser_out, 0);
      chk("rst_detrst", bus8.det_reset, 1);
      rst16 = 1'b0;
      rst8 = 1'b0;
      @(negedge clk);
      chk("acc_ready", bus8.word_ready, 0);
      chk("acc_busy", bus8.busy, 1);
      chk("clr_detrst", bus8.det_reset, 1);
      chk("clr_ser", bus8.ser_out, 0);
      bus8.word_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("ser_bit", bus8.ser_out, w[7-i]);
         chk("shift_detrst", bus8.det_reset, 0);
      end
      @(negedge clk);
      chk("drain_ser", bus8.ser_out, 0);
      wait_idle8();

      // 8'hAA and ready timing around done
      send8(8'hAA, 1'b1, 8'b00101010, 4'd3, CH ? 10 : 11);
      chk("ready8_busy", bus8.word_ready, 0);
      n = 0;
      while (bus8.done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("done8_seen", n < 40, 1);
      chk("ready8_at_done", bus8.word_ready, 0);
      @(negedge clk);
      chk("ready8_after_done", bus8.word_ready, 1);
      chk("busy8_after_done", bus8.busy, 0);
      chk("mask8_held", bus8.hit_mask, 8'b00101010);

      // 16-bit word, count saturates at 3
      q16.push_back({8'd19, 2'd3, 16'h2AAA});
      bus16.word_in = 16'hAAAA;
      bus16.word_valid = 1'b1;
      n = 0;
      while (bus16.word_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      bus16.word_valid = 1'b0;
      n = 0;
      while (q16.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("idle16_timeout", q16.size(), 0);

      // back-to-back words across a fresh reset
      rst8 = 1'b1;
      repeat (2) @(negedge clk);
      rst8 = 1'b0;
      base = pulses8;
      send8(8'b00000010, 1'b1, 8'h00, 4'd0, 11);
      send8(8'b10000000, 1'b1, CH ? 8'h80 : 8'h00,
            CH ? 4'd1 : 4'd0, CH ? 10 : 11);
      wait_idle8();
      chk("detrst_pulses", pulses8 - base, CH ? 1 : 2);

      // reset during SHIFT cycle 3 drops the word
      send8(8'hFF, 1'b0, 8'h00, 4'd0, 0);
      repeat (CH ? 3 : 4) @(negedge clk);
      rst8 = 1'b1;
      #1;
      chk("midrst_detrst", bus8.det_reset, 1);
      @(negedge clk);
      chk("midrst_busy", bus8.busy, 0);
      chk("midrst_ready", bus8.word_ready, 1);
      chk("midrst_cnt", bus8.hit_count, 0);
      chk("midrst_mask", bus8.hit_mask, 0);
      chk("midrst_ser", bus8.ser_out, 0);
      chk("midrst_done", bus8.done, 0);
      rst8 = 1'b0;
      repeat (20) @(negedge clk);
      chk("midrst_idle_busy", bus8.busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
